// File: rtl/io_reg_seq_pkg.sv
// Shared types for io_reg_seq: FSM state encoding, transaction class and
// default bank widths.
package io_reg_seq_pkg;

   localparam int OUT_W_DEF = 18;
   localparam int IN_W_DEF  = 8;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_WRITE   = 3'd1,
      S_CAPTURE = 3'd2,
      S_HOLD    = 3'd3,
      S_WAIT    = 3'd4,
      S_RESP    = 3'd5
   } state_t;

   typedef enum logic {
      CLS_WRITE   = 1'b0,
      CLS_CAPTURE = 1'b1
   } class_t;

endpackage

// File: rtl/io_reg_seq_rr_arb2.sv
// Two-requester round-robin arbiter. The grant is combinational from req and
// the pointer; the pointer moves to the other requester whenever take is high.
module io_reg_seq_rr_arb2 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   input  logic       take,
   output logic [1:0] grant,
   output logic       grant_idx
);

   logic ptr;

   // NOTE: always_comb assigns every output a default first so no latch is inferred.
   always_comb begin
      grant_idx = ptr;
      if (!req[ptr]) grant_idx = ~ptr;
      grant = '0;
      if (|req) grant[grant_idx] = 1'b1;
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)              ptr <= 1'b0;
      else if (take && |req)   ptr <= ~grant_idx;
   end

endmodule

// File: rtl/io_reg_seq.sv
// Sequencer for an output register bank (writes) and an input register bank
// (captures). Define IO_REG_SEQ_HOLD_EN to add a one-cycle HOLD step with FIXHOLD.
module io_reg_seq
   import io_reg_seq_pkg::*;
#(
   parameter int OUT_W = OUT_W_DEF,
   parameter int IN_W  = IN_W_DEF
) (
   input  logic             IQC,
   input  logic             QRT_N,
   input  logic [1:0]       REQ_VALID,
   input  logic [OUT_W-1:0] REQ_DATA0,
   input  logic [OUT_W-1:0] REQ_DATA1,
   output logic [1:0]       REQ_READY,
   output logic [OUT_W-1:0] OQI,
   output logic [OUT_W-1:0] OSEL,
   input  logic             CAP_REQ,
   input  logic [IN_W-1:0]  CAP_MASK,
   output logic [IN_W-1:0]  ISEL,
   output logic [IN_W-1:0]  FIXHOLD,
   input  logic [IN_W-1:0]  IQZ,
   output logic             CAP_VALID,
   output logic [IN_W-1:0]  CAP_DATA,
   output logic             BUSY
);

   state_t          state;
   class_t          last_class;
   logic [IN_W-1:0] cap_mask;
   logic            write_sel;
   logic            arb_take;
   logic [1:0]      arb_grant;
   logic            arb_idx;

`ifdef IO_REG_SEQ_HOLD_EN
   logic [IN_W-1:0] fixhold_q;
   assign FIXHOLD = fixhold_q;
`else
   assign FIXHOLD = '0;
`endif

   // A pending write only overtakes a capture request right after a capture.
   assign write_sel = (|REQ_VALID) && (!CAP_REQ || last_class == CLS_CAPTURE);
   assign arb_take  = (state == S_IDLE) && write_sel;

   io_reg_seq_rr_arb2 u_arb (
      .clk       (IQC),
      .rst_n     (QRT_N),
      .req       (REQ_VALID),
      .take      (arb_take),
      .grant     (arb_grant),
      .grant_idx (arb_idx)
   );

   // Outputs are registered alongside the state so each holds its value for
   // exactly the cycle the FSM spends in the corresponding state.
   always_ff @(posedge IQC or negedge QRT_N) begin
      if (!QRT_N) begin
         state      <= S_IDLE;
         last_class <= CLS_WRITE;
         cap_mask   <= '0;
         OQI        <= '0;
         OSEL       <= '0;
         REQ_READY  <= '0;
         ISEL       <= '0;
         CAP_VALID  <= 1'b0;
         CAP_DATA   <= '0;
         BUSY       <= 1'b0;
`ifdef IO_REG_SEQ_HOLD_EN
         fixhold_q  <= '0;
`endif
      end else begin
         OQI       <= '0;
         OSEL      <= '0;
         REQ_READY <= '0;
         ISEL      <= '0;
         CAP_VALID <= 1'b0;
`ifdef IO_REG_SEQ_HOLD_EN
         fixhold_q <= '0;
`endif
         unique case (state)
            S_IDLE: begin
               if (write_sel) begin
                  state     <= S_WRITE;
                  OQI       <= arb_idx ? REQ_DATA1 : REQ_DATA0;
                  OSEL      <= '1;
                  REQ_READY <= arb_grant;
                  BUSY      <= 1'b1;
               end else if (CAP_REQ) begin
                  state    <= S_CAPTURE;
                  cap_mask <= CAP_MASK;
                  ISEL     <= CAP_MASK;
                  BUSY     <= 1'b1;
`ifdef IO_REG_SEQ_HOLD_EN
                  fixhold_q <= CAP_MASK;
`endif
               end
            end
            S_WRITE: begin
               state      <= S_IDLE;
               last_class <= CLS_WRITE;
               BUSY       <= 1'b0;
            end
            S_CAPTURE: begin
`ifdef IO_REG_SEQ_HOLD_EN
               state     <= S_HOLD;
               fixhold_q <= cap_mask;
`else
               state     <= S_WAIT;
`endif
            end
            S_HOLD: begin
`ifdef IO_REG_SEQ_HOLD_EN
               state <= S_WAIT;
`else
               state <= S_IDLE;
               BUSY  <= 1'b0;
`endif
            end
            S_WAIT: begin
               state     <= S_RESP;
               CAP_DATA  <= IQZ & cap_mask;
               CAP_VALID <= 1'b1;
            end
            S_RESP: begin
               state      <= S_IDLE;
               last_class <= CLS_CAPTURE;
               BUSY       <= 1'b0;
            end
            default: begin
               state <= S_IDLE;
               BUSY  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_io_reg_seq.sv
// Directed bench for io_reg_seq: expected responses are queued as stimulus is
// issued and a negedge monitor pops and compares whenever the DUT responds.
module tb_io_reg_seq;

   localparam int OUT_W = 18;
   localparam int IN_W  = 8;
`ifdef IO_REG_SEQ_HOLD_EN
   localparam int CAP_LAT  = 4;
   localparam bit HOLD_ON  = 1'b1;
`else
   localparam int CAP_LAT  = 3;
   localparam bit HOLD_ON  = 1'b0;
`endif

   logic             IQC = 1'b0;
   logic             QRT_N = 1'b0;
   logic [1:0]       REQ_VALID = '0;
   logic [OUT_W-1:0] REQ_DATA0 = '0;
   logic [OUT_W-1:0] REQ_DATA1 = '0;
   logic [1:0]       REQ_READY;
   logic [OUT_W-1:0] OQI;
   logic [OUT_W-1:0] OSEL;
   logic             CAP_REQ = 1'b0;
   logic [IN_W-1:0]  CAP_MASK = '0;
   logic [IN_W-1:0]  ISEL;
   logic [IN_W-1:0]  FIXHOLD;
   logic [IN_W-1:0]  IQZ = '0;
   logic             CAP_VALID;
   logic [IN_W-1:0]  CAP_DATA;
   logic             BUSY;

   io_reg_seq dut (
      .IQC       (IQC),
      .QRT_N     (QRT_N),
      .REQ_VALID (REQ_VALID),
      .REQ_DATA0 (REQ_DATA0),
      .REQ_DATA1 (REQ_DATA1),
      .REQ_READY (REQ_READY),
      .OQI       (OQI),
      .OSEL      (OSEL),
      .CAP_REQ   (CAP_REQ),
      .CAP_MASK  (CAP_MASK),
      .ISEL      (ISEL),
      .FIXHOLD   (FIXHOLD),
      .IQZ       (IQZ),
      .CAP_VALID (CAP_VALID),
      .CAP_DATA  (CAP_DATA),
      .BUSY      (BUSY)
   );

   always #5 IQC = ~IQC;

   typedef struct packed {
      logic             is_cap;
      logic [1:0]       ready;
      logic [OUT_W-1:0] data;
   } exp_t;

   exp_t sb[$];
   exp_t e;
   int   total = 0;
   int   bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
      end
   endtask

   function automatic exp_t mk(input logic c, input logic [1:0] r, input logic [OUT_W-1:0] d);
      return {c, r, d};
   endfunction

   // Scoreboard monitor
   always @(negedge IQC) begin
      if (QRT_N === 1'b1 && (REQ_READY !== 2'b00 || CAP_VALID !== 1'b0)) begin
         if (sb.size() == 0) begin
            check("sb_unexpected", {29'd0, REQ_READY, CAP_VALID}, 32'd0);
         end else begin
            e = sb.pop_front();
            check("sb_kind", {31'd0, CAP_VALID}, {31'd0, e.is_cap});
            if (e.is_cap) begin
               check("sb_cap_data", {24'd0, CAP_DATA}, {14'd0, e.data});
            end else begin
               check("sb_ready", {30'd0, REQ_READY}, {30'd0, e.ready});
               check("sb_oqi", {14'd0, OQI}, {14'd0, e.data});
               check("sb_osel", {14'd0, OSEL}, 32'h3FFFF);
            end
         end
      end
   end

   task automatic tick();
      @(posedge IQC);
      #1;
   endtask

   task automatic do_reset();
      #1;
      QRT_N = 1'b0;
      REQ_VALID = '0;
      CAP_REQ = 1'b0;
      repeat (2) @(posedge IQC);
      #3;
      QRT_N = 1'b1;
   endtask

   task automatic run_capture(input logic [7:0] mask, input logic [7:0] iqz, input logic [7:0] exp_data);
      int   n;
      logic got;
      CAP_MASK = mask;
      IQZ      = iqz;
      CAP_REQ  = 1'b1;
      sb.push_back(mk(1'b1, 2'b00, {10'd0, exp_data}));
      n   = 0;
      got = 1'b0;
      while (!got && n < 12) begin
         tick();
         n++;
         if (n == 1) begin
            check("isel_capture", {24'd0, ISEL}, {24'd0, mask});
            check("fixhold_capture", {24'd0, FIXHOLD}, HOLD_ON ? {24'd0, mask} : 32'd0);
         end
         if (n == 2) begin
            check("isel_after", {24'd0, ISEL}, 32'd0);
            check("fixhold_second", {24'd0, FIXHOLD}, HOLD_ON ? {24'd0, mask} : 32'd0);
         end
         if (n == 3) check("fixhold_third", {24'd0, FIXHOLD}, 32'd0);
         if (CAP_VALID === 1'b1) begin
            got = 1'b1;
            check("cap_latency", n, CAP_LAT);
            CAP_REQ = 1'b0;
         end
      end
      check("cap_seen", {31'd0, got}, 32'd1);
      tick();
      IQZ = ~iqz;
      check("cap_valid_one_cycle", {31'd0, CAP_VALID}, 32'd0);
      check("busy_idle", {31'd0, BUSY}, 32'd0);
      tick();
      check("cap_data_hold", {24'd0, CAP_DATA}, {24'd0, exp_data});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      int   n;
      int   isel_cyc;
      logic wdone;
      logic [1:0] ready_pat [8];
      int   acc0, acc1;

      // Reset state
      #2;
      check("rst_oqi", {14'd0, OQI}, 32'd0);
      check("rst_osel", {14'd0, OSEL}, 32'd0);
      check("rst_ready", {30'd0, REQ_READY}, 32'd0);
      check("rst_cap_valid", {31'd0, CAP_VALID}, 32'd0);
      check("rst_cap_data", {24'd0, CAP_DATA}, 32'd0);
      check("rst_busy", {31'd0, BUSY}, 32'd0);
      do_reset();

      // Single write from requester 0
      REQ_DATA0 = 18'h2A5A5;
      REQ_VALID = 2'b01;
      sb.push_back(mk(1'b0, 2'b01, 18'h2A5A5));
      tick();
      check("w1_ready", {30'd0, REQ_READY}, 32'd1);
      check("w1_oqi", {14'd0, OQI}, 32'h2A5A5);
      check("w1_osel", {14'd0, OSEL}, 32'h3FFFF);
      check("w1_busy", {31'd0, BUSY}, 32'd1);
      REQ_VALID = 2'b00;
      tick();
      check("w1_osel_idle", {14'd0, OSEL}, 32'd0);
      check("w1_ready_idle", {30'd0, REQ_READY}, 32'd0);
      check("w1_busy_idle", {31'd0, BUSY}, 32'd0);

      // Both requesters contend: grants 0,1,0,1 every second cycle
      do_reset();
      ready_pat = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};
      REQ_DATA0 = 18'h00A01;
      REQ_DATA1 = 18'h3B001;
      REQ_VALID = 2'b11;
      sb.push_back(mk(1'b0, 2'b01, 18'h00A01));
      sb.push_back(mk(1'b0, 2'b10, 18'h3B001));
      sb.push_back(mk(1'b0, 2'b01, 18'h00A02));
      sb.push_back(mk(1'b0, 2'b10, 18'h3B002));
      acc0 = 0;
      acc1 = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         check("rr_ready_pattern", {30'd0, REQ_READY}, {30'd0, ready_pat[i]});
         if (REQ_READY[0] === 1'b1) begin
            acc0++;
            REQ_DATA0 = 18'h00A02;
            if (acc0 == 2) REQ_VALID[0] = 1'b0;
         end
         if (REQ_READY[1] === 1'b1) begin
            acc1++;
            REQ_DATA1 = 18'h3B002;
            if (acc1 == 2) REQ_VALID[1] = 1'b0;
         end
      end

      // Captures: normal, empty mask, sparse mask
      do_reset();
      run_capture(8'h0F, 8'hFF, 8'h0F);
      run_capture(8'h00, 8'hFF, 8'h00);
      run_capture(8'h81, 8'hF0, 8'h80);

      // Capture and write together: capture first, then the write
      do_reset();
      REQ_DATA1 = 18'h15555;
      REQ_VALID = 2'b10;
      CAP_MASK  = 8'h3C;
      IQZ       = 8'hFF;
      CAP_REQ   = 1'b1;
      sb.push_back(mk(1'b1, 2'b00, 18'h0003C));
      sb.push_back(mk(1'b0, 2'b10, 18'h15555));
      isel_cyc = 0;
      wdone = 1'b0;
      n = 0;
      while (!wdone && n < 20) begin
         tick();
         n++;
         if (ISEL !== '0) isel_cyc++;
         if (CAP_VALID === 1'b1) CAP_REQ = 1'b0;
         if (REQ_READY[1] === 1'b1) begin
            REQ_VALID = 2'b00;
            wdone = 1'b1;
            check("mixed_write_cycle", n, CAP_LAT + 2);
         end
      end
      check("mixed_write_seen", {31'd0, wdone}, 32'd1);
      check("mixed_single_capture", isel_cyc, 1);
      tick();

      // Reset pulsed during WAIT aborts the capture
      CAP_MASK = 8'hFF;
      IQZ      = 8'hFF;
      CAP_REQ  = 1'b1;
      for (int i = 0; i < CAP_LAT - 1; i++) tick();
      check("abort_busy_before", {31'd0, BUSY}, 32'd1);
      #2;
      QRT_N = 1'b0;
      #1;
      check("abort_cap_valid", {31'd0, CAP_VALID}, 32'd0);
      check("abort_cap_data", {24'd0, CAP_DATA}, 32'd0);
      check("abort_busy", {31'd0, BUSY}, 32'd0);
      check("abort_isel", {24'd0, ISEL}, 32'd0);
      check("abort_fixhold", {24'd0, FIXHOLD}, 32'd0);
      check("abort_osel", {14'd0, OSEL}, 32'd0);
      check("abort_oqi", {14'd0, OQI}, 32'd0);
      check("abort_ready", {30'd0, REQ_READY}, 32'd0);
      CAP_REQ = 1'b0;
      repeat (2) @(posedge IQC);
      #3;
      QRT_N = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         check("abort_no_resp", {31'd0, CAP_VALID}, 32'd0);
         check("abort_idle", {31'd0, BUSY}, 32'd0);
      end

      // Pointer restarts at requester 0 after reset
      REQ_DATA0 = 18'h11111;
      REQ_DATA1 = 18'h22222;
      REQ_VALID = 2'b11;
      sb.push_back(mk(1'b0, 2'b01, 18'h11111));
      sb.push_back(mk(1'b0, 2'b10, 18'h22222));
      n = 0;
      while (REQ_VALID != 2'b00 && n < 10) begin
         tick();
         n++;
         if (REQ_READY[0] === 1'b1) REQ_VALID[0] = 1'b0;
         if (REQ_READY[1] === 1'b1) REQ_VALID[1] = 1'b0;
      end
      check("post_reset_writes_done", {30'd0, REQ_VALID}, 32'd0);
      tick();
      tick();

      check("sb_drained", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
